// File: rtl/sample_sequencer_if.sv
// Handshake bundle between the sample sequencer (master) and its ADC, processor
// and DAC/PWM neighbours (slave).
interface sample_sequencer_if #(
  parameter int unsigned DW = 10
);
  logic          adc_start;
  logic          adc_channel;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          proc_start;
  logic [DW-1:0] proc_a;
  logic [DW-1:0] proc_b;
  logic [DW-1:0] proc_dout;
  logic          proc_done;
  logic [DW-1:0] dac_data;
  logic          dac_load;

  modport master (
    output adc_start, adc_channel,
    input  adc_data, adc_valid,
    output proc_start, proc_a, proc_b,
    input  proc_dout, proc_done,
    output dac_data, dac_load
  );

  modport slave (
    input  adc_start, adc_channel,
    output adc_data, adc_valid,
    input  proc_start, proc_a, proc_b,
    output proc_dout, proc_done,
    input  dac_data, dac_load
  );
endinterface

// File: rtl/sample_sequencer.sv
// Per-sample scheduler: on each tick converts CH0 then CH1, runs one processor pass
// and loads the result into the DAC/PWM register, with wait timeout and overrun flags.
module sample_sequencer #(
  parameter int unsigned DW          = 10,
  parameter int unsigned TIMEOUT_CYC = 4000,
  parameter int unsigned TW          = 13
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               clr_flags,
  sample_sequencer_if.master bus,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    CONV0,
    WAIT0,
    CONV1,
    WAIT1,
    PROC,
    WAITP,
    LOAD
  } state_t;

  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          adc_start_q;
  logic          adc_channel_q;
  logic          proc_start_q;
  logic          dac_load_q;
  logic [DW-1:0] proc_a_q;
  logic [DW-1:0] proc_b_q;
  logic [DW-1:0] dac_data_q;
  logic          in_wait;
  logic          pulse_seen;
  logic          abort;

  // Only the pulse belonging to the current wait state counts; the expected pulse
  // wins over an expiring counter in the same cycle.
  always_comb begin
    in_wait    = 1'b0;
    pulse_seen = 1'b0;
    case (state)
      WAIT0, WAIT1: begin
        in_wait    = 1'b1;
        pulse_seen = bus.adc_valid;
      end
      WAITP: begin
        in_wait    = 1'b1;
        pulse_seen = bus.proc_done;
      end
      default: begin
        in_wait    = 1'b0;
        pulse_seen = 1'b0;
      end
    endcase
    abort = in_wait && !pulse_seen && (wait_cnt == CNT_LIMIT);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      adc_start_q   <= 1'b0;
      adc_channel_q <= 1'b0;
      proc_start_q  <= 1'b0;
      dac_load_q    <= 1'b0;
      proc_a_q      <= '0;
      proc_b_q      <= '0;
      dac_data_q    <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      adc_start_q  <= 1'b0;
      proc_start_q <= 1'b0;
      dac_load_q   <= 1'b0;

      if (tick && busy) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end

      if (abort) begin
        timeout_err <= 1'b1;
      end else if (clr_flags) begin
        timeout_err <= 1'b0;
      end

      // Strobes and busy are set on the transition into their state so that they
      // are registered yet line up exactly with the state they belong to.
      case (state)
        IDLE: begin
          if (tick) begin
            state         <= CONV0;
            busy          <= 1'b1;
            adc_start_q   <= 1'b1;
            adc_channel_q <= 1'b0;
          end
        end
        CONV0: begin
          state    <= WAIT0;
          wait_cnt <= '0;
        end
        WAIT0: begin
          if (pulse_seen) begin
            proc_a_q      <= bus.adc_data;
            state         <= CONV1;
            adc_start_q   <= 1'b1;
            adc_channel_q <= 1'b1;
          end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        CONV1: begin
          state    <= WAIT1;
          wait_cnt <= '0;
        end
        WAIT1: begin
          if (pulse_seen) begin
            proc_b_q     <= bus.adc_data;
            state        <= PROC;
            proc_start_q <= 1'b1;
          end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        PROC: begin
          state    <= WAITP;
          wait_cnt <= '0;
        end
        WAITP: begin
          if (pulse_seen) begin
            dac_data_q <= bus.proc_dout;
            state      <= LOAD;
            dac_load_q <= 1'b1;
          end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.adc_start   = adc_start_q;
  assign bus.adc_channel = adc_channel_q;
  assign bus.proc_start  = proc_start_q;
  assign bus.proc_a      = proc_a_q;
  assign bus.proc_b      = proc_b_q;
  assign bus.dac_data    = dac_data_q;
  assign bus.dac_load    = dac_load_q;

endmodule
